// File: rtl/regfile_bypass_sb_pkg.sv
// Shared definitions for the bypassing register file with load scoreboard.
// Contents:
//   - default widths and register counts used as parameter defaults
//   - REG_ZERO: index of the hardwired zero register
//   - SP_IDX_DEF / SP_RESET_DEF: stack pointer index and its reset value
//   - reg_implemented(): true for an address that maps to writable storage
package regfile_bypass_sb_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int NUM_REGS_DEF = 32;
  localparam int unsigned REG_ZERO = 0;
  localparam int SP_IDX_DEF   = 29;
  localparam int SP_RESET_DEF = 252;

  // Address 0 is the zero register and addresses past the last implemented
  // register have no storage; neither may be written, marked or read.
  function automatic logic reg_implemented(input int unsigned addr,
                                           input int unsigned num_regs);
    return (addr != REG_ZERO) && (addr < num_regs);
  endfunction

endpackage

// File: rtl/regfile_bypass_sb_if.sv
// Bundle of read, write and scoreboard signals of the register file.
// Protocol: no handshake. Read address in, read data/busy out in the same
// cycle (combinational). Write and mark enables are single-cycle qualifiers
// sampled on the rising clock edge; there is no backpressure.
// Modports:
//   master - decode/writeback side (drives addresses, enables, data)
//   slave  - register file (drives read data, busy bits, wr_conflict)
interface regfile_bypass_sb_if
  import regfile_bypass_sb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic [ADDR_W-1:0] rd_addrA;
  logic [ADDR_W-1:0] rd_addrB;
  logic [DATA_W-1:0] rd_dataA;
  logic [DATA_W-1:0] rd_dataB;
  logic              rd_busyA;
  logic              rd_busyB;
  logic              wr0_en;
  logic [ADDR_W-1:0] wr0_addr;
  logic [DATA_W-1:0] wr0_data;
  logic              wr1_en;
  logic [ADDR_W-1:0] wr1_addr;
  logic [DATA_W-1:0] wr1_data;
  logic              mark_en;
  logic [ADDR_W-1:0] mark_addr;
  logic              wr_conflict;

  modport master (
    output rd_addrA, rd_addrB,
    input  rd_dataA, rd_dataB, rd_busyA, rd_busyB,
    output wr0_en, wr0_addr, wr0_data,
    output wr1_en, wr1_addr, wr1_data,
    output mark_en, mark_addr,
    input  wr_conflict
  );

  modport slave (
    input  rd_addrA, rd_addrB,
    output rd_dataA, rd_dataB, rd_busyA, rd_busyB,
    input  wr0_en, wr0_addr, wr0_data,
    input  wr1_en, wr1_addr, wr1_data,
    input  mark_en, mark_addr,
    output wr_conflict
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard for load-use hazard detection.
// Ports:
//   elk, nrst            clock, synchronous active-low reset
//   mark_en/mark_addr    set busy bit (load issued)
//   clr_en/clr_addr      clear busy bit (load writeback)
//   rd_addr_a/rd_addr_b  lookup addresses
//   busy_a/busy_b        combinational busy bits for the lookups
module regfile_scoreboard
  import regfile_bypass_sb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int BYPASS   = 1
) (
  input  logic              elk,
  input  logic              nrst,
  input  logic              mark_en,
  input  logic [ADDR_W-1:0] mark_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              busy_a,
  output logic              busy_b
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en && reg_implemented(32'(clr_addr), NUM_REGS)) begin
      busy_d[clr_addr] = 1'b0;
    end
    // Applied after the clear so a new load issued on the same edge wins.
    if (mark_en && reg_implemented(32'(mark_addr), NUM_REGS)) begin
      busy_d[mark_addr] = 1'b1;
    end
  end

  always_ff @(posedge elk) begin
    if (!nrst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // A writeback landing this cycle already resolves the hazard, unless a new
  // load to the same register is being issued at the same time.
  function automatic logic busy_lookup(input logic [ADDR_W-1:0] a);
    logic b;
    b = 1'b0;
    if (reg_implemented(32'(a), NUM_REGS)) begin
      b = busy_q[a];
      if ((BYPASS != 0) && clr_en && (clr_addr == a) &&
          !(mark_en && (mark_addr == a))) begin
        b = 1'b0;
      end
    end
    return b;
  endfunction

  always_comb begin
    busy_a = busy_lookup(rd_addr_a);
    busy_b = busy_lookup(rd_addr_b);
  end

endmodule

// File: rtl/regfile_bypass_sb.sv
// Integer register file: two combinational read ports, two clocked write
// ports (wr0 = ALU writeback, wr1 = load writeback), write-to-read bypass,
// hardwired zero register, stack pointer preset on reset and a busy
// scoreboard for load-use hazards.
// Ports:
//   elk   clock, all state updates on the rising edge
//   nrst  synchronous active-low reset
//   bus   regfile_bypass_sb_if.slave: read/write/mark signals, wr_conflict
module regfile_bypass_sb
  import regfile_bypass_sb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int SP_IDX   = SP_IDX_DEF,
  parameter int SP_RESET = SP_RESET_DEF,
  parameter int BYPASS   = 1
) (
  input logic                 elk,
  input logic                 nrst,
  regfile_bypass_sb_if.slave  bus
);

  logic              wr0_en;
  logic [ADDR_W-1:0] wr0_addr;
  logic [DATA_W-1:0] wr0_data;
  logic              wr1_en;
  logic [ADDR_W-1:0] wr1_addr;
  logic [DATA_W-1:0] wr1_data;
  logic              wr0_ok;
  logic              wr1_ok;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              conflict_q;
  logic              conflict_d;

  assign wr0_en   = bus.wr0_en;
  assign wr0_addr = bus.wr0_addr;
  assign wr0_data = bus.wr0_data;
  assign wr1_en   = bus.wr1_en;
  assign wr1_addr = bus.wr1_addr;
  assign wr1_data = bus.wr1_data;

  assign wr0_ok = wr0_en && reg_implemented(32'(wr0_addr), NUM_REGS);
  assign wr1_ok = wr1_en && reg_implemented(32'(wr1_addr), NUM_REGS);

  // Write arbitration: wr1 first, wr0 second, so on a collision the ALU
  // result is what lands in storage.
  always_comb begin
    regs_d = regs_q;
    if (wr1_ok) begin
      regs_d[wr1_addr] = wr1_data;
    end
    if (wr0_ok) begin
      regs_d[wr0_addr] = wr0_data;
    end
  end

  assign conflict_d = wr0_ok && wr1_ok && (wr0_addr == wr1_addr);

  always_ff @(posedge elk) begin
    if (!nrst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == SP_IDX) ? DATA_W'(SP_RESET) : '0;
      end
      conflict_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      conflict_q <= conflict_d;
    end
  end

  assign bus.wr_conflict = conflict_q;

  // Read mux: zero/unimplemented first so an out-of-range address never
  // indexes storage; forwarding ignores nrst because it only affects storage.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] r;
    r = '0;
    if (reg_implemented(32'(a), NUM_REGS)) begin
      if ((BYPASS != 0) && wr0_en && (wr0_addr == a)) begin
        r = wr0_data;
      end else if ((BYPASS != 0) && wr1_en && (wr1_addr == a)) begin
        r = wr1_data;
      end else begin
        r = regs_q[a];
      end
    end
    return r;
  endfunction

  always_comb begin
    bus.rd_dataA = read_port(bus.rd_addrA);
    bus.rd_dataB = read_port(bus.rd_addrB);
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .elk       (elk),
    .nrst      (nrst),
    .mark_en   (bus.mark_en),
    .mark_addr (bus.mark_addr),
    .clr_en    (wr1_en),
    .clr_addr  (wr1_addr),
    .rd_addr_a (bus.rd_addrA),
    .rd_addr_b (bus.rd_addrB),
    .busy_a    (bus.rd_busyA),
    .busy_b    (bus.rd_busyB)
  );

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Bench for regfile_bypass_sb: directed scenarios followed by random traffic.
// A reference model (plain arrays) predicts every cycle's read data, busy
// bits and wr_conflict; predictions go into exp_q and a negedge monitor
// pops and compares them against the DUT.
module tb_regfile_bypass_sb;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NREGS = 32;
  localparam int SP    = 29;
  localparam int SPRST = 252;
  localparam int EXP_W = 2 * DW + 3;

  // ---------------- clock / reset ----------------
  logic elk;
  logic nrst;

  initial elk = 1'b0;
  always #5 elk = ~elk;

  regfile_bypass_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_bypass_sb dut (
    .elk  (elk),
    .nrst (nrst),
    .bus  (bus)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] mem_m [NREGS];
  bit            busy_m [NREGS];
  bit            conf_m;
  bit            model_known;

  // Inputs currently applied to the DUT (bench-side copy).
  bit            c_nrst;
  int            c_ra, c_rb, c_w0a, c_w1a, c_ma;
  bit            c_w0e, c_w1e, c_me;
  logic [DW-1:0] c_w0d, c_w1d;

  logic [EXP_W-1:0] exp_q[$];
  int n_checks;
  int n_err;
  int cyc;

  function automatic bit impl(input int a);
    return (a != 0) && (a < NREGS);
  endfunction

  // Effect of the edge that just sampled the c_* inputs.
  task automatic model_commit();
    if (!c_nrst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_m[i]  = (i == SP) ? DW'(SPRST) : '0;
        busy_m[i] = 0;
      end
      conf_m = 0;
      model_known = 1;
    end else if (model_known) begin
      conf_m = c_w0e && c_w1e && (c_w0a == c_w1a) && impl(c_w0a);
      if (c_w1e && impl(c_w1a)) begin
        mem_m[c_w1a]  = c_w1d;
        busy_m[c_w1a] = 0;
      end
      if (c_w0e && impl(c_w0a)) mem_m[c_w0a] = c_w0d;
      if (c_me && impl(c_ma)) busy_m[c_ma] = 1;
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input int a);
    if (!impl(a)) return '0;
    if (c_w0e && c_w0a == a) return c_w0d;
    if (c_w1e && c_w1a == a) return c_w1d;
    return mem_m[a];
  endfunction

  function automatic bit exp_busy(input int a);
    if (!impl(a)) return 0;
    if (c_w1e && c_w1a == a && !(c_me && c_ma == a)) return 0;
    return busy_m[a];
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit n, input int ra, input int rb,
                      input bit w0e, input int w0a, input logic [DW-1:0] w0d,
                      input bit w1e, input int w1a, input logic [DW-1:0] w1d,
                      input bit me, input int ma);
    @(posedge elk);
    #1;
    model_commit();
    c_nrst = n; c_ra = ra; c_rb = rb;
    c_w0e = w0e; c_w0a = w0a; c_w0d = w0d;
    c_w1e = w1e; c_w1a = w1a; c_w1d = w1d;
    c_me = me; c_ma = ma;
    nrst          = n;
    bus.rd_addrA  = AW'(ra);
    bus.rd_addrB  = AW'(rb);
    bus.wr0_en    = w0e;
    bus.wr0_addr  = AW'(w0a);
    bus.wr0_data  = w0d;
    bus.wr1_en    = w1e;
    bus.wr1_addr  = AW'(w1a);
    bus.wr1_data  = w1d;
    bus.mark_en   = me;
    bus.mark_addr = AW'(ma);
    if (model_known) begin
      exp_q.push_back({exp_data(ra), exp_data(rb), exp_busy(ra), exp_busy(rb), conf_m});
    end
  endtask

  task automatic idle(input int ra, input int rb);
    step(1, ra, rb, 0, 0, '0, 0, 0, '0, 0, 0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  always @(negedge elk) begin
    logic [EXP_W-1:0] e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rd_dataA",    bus.rd_dataA,          e[EXP_W-1 -: DW]);
      check("rd_dataB",    bus.rd_dataB,          e[DW+2 -: DW]);
      check("rd_busyA",    DW'(bus.rd_busyA),     DW'(e[2]));
      check("rd_busyB",    DW'(bus.rd_busyB),     DW'(e[1]));
      check("wr_conflict", DW'(bus.wr_conflict),  DW'(e[0]));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int ra, rb, w0a, w1a, ma;
    n_checks = 0; n_err = 0; cyc = 0; model_known = 0;
    c_nrst = 0; c_ra = 0; c_rb = 0; c_w0e = 0; c_w0a = 0; c_w0d = '0;
    c_w1e = 0; c_w1a = 0; c_w1d = '0; c_me = 0; c_ma = 0;
    nrst = 0;
    bus.rd_addrA = '0; bus.rd_addrB = '0;
    bus.wr0_en = 0; bus.wr0_addr = '0; bus.wr0_data = '0;
    bus.wr1_en = 0; bus.wr1_addr = '0; bus.wr1_data = '0;
    bus.mark_en = 0; bus.mark_addr = '0;

    // Reset held for two edges, with writes and a mark that must be ignored.
    step(0, 0, 0, 1, 3, 32'h1111_1111, 1, 4, 32'h2222_2222, 1, 5);
    step(0, 0, 0, 1, 3, 32'h1111_1111, 1, 4, 32'h2222_2222, 1, 5);
    // Sweep every address after reset: data and busy.
    for (int a = 0; a < NREGS; a++) idle(a, 29);
    idle(5, 29);

    // Write and read back.
    step(1, 0, 0, 1, 8, 32'hDEAD_BEEF, 0, 0, '0, 0, 0);
    idle(8, 8);

    // Bypass from wr1, then stored value.
    step(1, 0, 9, 0, 0, '0, 1, 9, 32'h0000_1234, 0, 0);
    idle(9, 9);

    // Zero register via both ports: no storage, no conflict.
    step(1, 0, 0, 1, 0, 32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFF, 0, 0);
    idle(0, 0);
    idle(0, 0);

    // Collision on reg10: wr0 wins, conflict for one cycle.
    step(1, 10, 10, 1, 10, 32'h0000_AAAA, 1, 10, 32'h0000_5555, 0, 0);
    idle(10, 10);
    idle(10, 10);

    // Scoreboard sequence on reg12.
    step(1, 12, 12, 0, 0, '0, 0, 0, '0, 1, 12);
    idle(12, 12);
    step(1, 12, 12, 0, 0, '0, 1, 12, 32'd7, 0, 0);
    idle(12, 12);
    step(1, 12, 12, 0, 0, '0, 0, 0, '0, 1, 12);
    step(1, 12, 12, 0, 0, '0, 1, 12, 32'd9, 1, 12);
    idle(12, 12);
    step(0, 12, 12, 0, 0, '0, 0, 0, '0, 0, 0);
    idle(12, 12);
    // Mark of register 0 is ignored.
    step(1, 0, 0, 0, 0, '0, 0, 0, '0, 1, 0);
    idle(0, 12);

    // Random traffic biased to a few registers so hits and collisions occur.
    for (int i = 0; i < 600; i++) begin
      ra  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 6);
      rb  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 6);
      w0a = $urandom_range(0, 6);
      w1a = $urandom_range(0, 6);
      ma  = $urandom_range(0, 6);
      step(($urandom_range(0, 60) != 0), ra, rb,
           1'($urandom_range(0, 1)), w0a, $urandom,
           1'($urandom_range(0, 1)), w1a, $urandom,
           1'($urandom_range(0, 2) == 0), ma);
    end
    idle(0, 0);

    @(posedge elk);
    @(negedge elk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain cycle=%0d actual=%0d expected=0 pending", cyc, exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_bypass_sb.md
Name: regfile_bypass_sb

Overview:
- Parametrised successor to the core's 32-entry integer register file.
- Two combinational read ports and two clocked write ports: wr0 is ALU writeback, wr1 is load writeback.
- Write-to-read bypass, hardwired zero register, synchronous reset to defined values (stack pointer preset).
- Per-register busy scoreboard so the decode stage can detect load-use hazards.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width
- NUM_REGS, 32, implemented registers (<= 2**ADDR_W); addresses >= NUM_REGS unimplemented
- SP_IDX, 29, index of stack pointer register
- SP_RESET, 252, reset value of register SP_IDX
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads show stored value only

Ports:
- elk  in  1  clock, all state updates on rising edge
- nrst  in  1  reset, synchronous, active-low
- rd_addrA  in  ADDR_W  read port A address
- rd_addrB  in  ADDR_W  read port B address
- rd_dataA  out  DATA_W  read port A data (combinational)
- rd_dataB  out  DATA_W  read port B data (combinational)
- rd_busyA  out  1  scoreboard busy bit for rd_addrA (combinational)
- rd_busyB  out  1  scoreboard busy bit for rd_addrB (combinational)
- wr0_en  in  1  ALU write enable
- wr0_addr  in  ADDR_W  ALU write address
- wr0_data  in  DATA_W  ALU write data
- wr1_en  in  1  load write enable; also clears busy bit
- wr1_addr  in  ADDR_W  load write address
- wr1_data  in  DATA_W  load write data
- mark_en  in  1  set busy bit (load issued)
- mark_addr  in  ADDR_W  register to mark busy
- wr_conflict  out  1  registered pulse: previous cycle had wr0/wr1 collision on same valid address

Behaviour:
- Reset: nrst=0 at a rising edge of elk:
  - all registers -> 0, except reg[SP_IDX] -> SP_RESET
  - all busy bits -> 0; wr_conflict -> 0
  - all writes and marks in that cycle are ignored
- Read outputs are combinational: after reset they show 0 (SP_RESET for SP_IDX) and busy = 0; no reset value of their own.
- Writes:
  - On a rising edge with nrst=1, wrN_en=1 stores wrN_data at wrN_addr.
  - Address 0 and addresses >= NUM_REGS: writes ignored.
- Collision: wr0_en and wr1_en both 1, same valid nonzero address -> wr0_data is stored; wr_conflict = 1 for the next cycle only.
- Read order, evaluated per port:
  - address 0 or unimplemented -> data 0, busy 0;
  - else, if BYPASS=1 and wr0_en hits the address -> wr0_data;
  - else, if BYPASS=1 and wr1_en hits the address -> wr1_data;
  - else the stored value.
  - Bypass is independent of nrst; reset dominance applies to storage only.
- Scoreboard:
  - mark_en sets busy[mark_addr] at the edge; wr1_en clears busy[wr1_addr] at the edge.
  - Same-edge set and clear on the same address: set wins (a new load is issued).
  - wr0 never touches busy.
  - mark of address 0 or an unimplemented address is ignored.
- Busy read:
  - rd_busyX = busy[rd_addrX];
  - with BYPASS=1, forced to 0 when wr1_en is writing that address this cycle and mark_en does not target it.
- Latency:
  - a write is visible at the next edge (0 cycles with BYPASS);
  - busy set is visible from the cycle after mark_en.
- No X propagation: unimplemented reads return 0, never an array out-of-range value.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults, REG_ZERO=0, SP_IDX default, SP_RESET default.
- One sub-module, regfile_scoreboard: busy vector, mark/clear logic and set-over-clear priority, plus busy read muxing.
- Storage, write arbitration and bypass stay in the top.

Test Plan:
- Reset: hold nrst=0 for 2 edges, release -> read reg29=252, reg5=0, rd_busyA=0 for every address, wr_conflict=0.
- Write and read back: wr0 reg8=0xDEADBEEF -> next cycle rd_dataA(8)=0xDEADBEEF.
- Bypass: in the same cycle, wr1 reg9=0x1234 and rd_addrB=9 -> rd_dataB=0x1234 before the edge, and stored after.
- Zero register: write reg0=0xFFFFFFFF via wr0 and wr1 -> rd_dataA(0)=0, no wr_conflict.
- Collision: wr0 reg10=0xAAAA and wr1 reg10=0x5555 on one edge -> reg10=0xAAAA, wr_conflict=1 for exactly one cycle.
- Scoreboard:
  - mark reg12 -> rd_busyA(12)=1 next cycle;
  - wr1 reg12=7 with no mark -> rd_busyA=0 in the same cycle (bypass) and stays 0 after;
  - mark and wr1 on reg12 at the same edge -> busy stays 1;
  - nrst=0 with reg12 busy -> busy cleared and reg12=0.
